// File: rtl/pipelined_itcm.sv
// rtl/pipelined_itcm.sv - Fixed-latency, in-order instruction TCM model with credit flow and flush
// Program memory is a ROM image parameter; pmem_reads_q counts individual lane reads.
module pipelined_itcm #(
   parameter int                      FETCH_WIDTH = 2,
   parameter int                      LATENCY     = 1,
   parameter int                      DEPTH       = 4,
   parameter int                      PMEM_WORDS  = 256,
   parameter logic [32*PMEM_WORDS-1:0] PMEM_IMAGE = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush_frontend,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_addr,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_addr,
   output logic [32*FETCH_WIDTH-1:0] rsp_data,
   output logic [FETCH_WIDTH-1:0]    rsp_mask,
   output logic [31:0]               fetch_count
);

   localparam int DW     = 32 * FETCH_WIDTH;
   localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int PM_AW  = (PMEM_WORDS > 1) ? $clog2(PMEM_WORDS) : 1;

   logic                 accept;
   logic                 pop;
   logic [31:0]          fill_addr;
   logic [SLOT_W-1:0]    fill_slot;
   logic [DW-1:0]        fill_data;
   logic [FETCH_WIDTH-1:0] fill_mask;
   logic [31:0]          fill_reads;

   logic                 wr_en;
   logic [31:0]          wr_addr;
   logic [DW-1:0]        wr_data;
   logic [FETCH_WIDTH-1:0] wr_mask;

   logic [CNT_W-1:0]     outstanding_q, outstanding_d;
   logic [31:0]          fetch_count_q, fetch_count_d;
   logic [31:0]          pmem_reads_q, pmem_reads_d;

   logic [31:0]          fifo_addr_q [DEPTH];
   logic [31:0]          fifo_addr_d [DEPTH];
   logic [DW-1:0]        fifo_data_q [DEPTH];
   logic [DW-1:0]        fifo_data_d [DEPTH];
   logic [FETCH_WIDTH-1:0] fifo_mask_q [DEPTH];
   logic [FETCH_WIDTH-1:0] fifo_mask_d [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;

   logic                 unused_addr_lsbs;
   assign unused_addr_lsbs = ^req_addr[1:0];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credits cover pipeline plus FIFO, so a pop only frees a slot from the next cycle on.
   assign req_ready = ~reset & (outstanding_q < CNT_W'(DEPTH));
   assign accept    = req_valid & req_ready & ~flush_frontend;
   assign rsp_valid = (fifo_cnt_q != '0);
   assign pop       = rsp_valid & rsp_ready;

   assign rsp_addr    = fifo_addr_q[rd_ptr_q];
   assign rsp_data    = fifo_data_q[rd_ptr_q];
   assign rsp_mask    = fifo_mask_q[rd_ptr_q];
   assign fetch_count = fetch_count_q;

   // Lanes start at the slot within the fetch block and stop at the block end.
   always_comb begin
      fill_addr  = {req_addr[31:2], 2'b00};
      fill_slot  = '0;
      if (FETCH_WIDTH > 1) begin
         fill_slot = fill_addr[SLOT_W+1:2];
      end
      fill_data  = '0;
      fill_mask  = '0;
      fill_reads = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (i < FETCH_WIDTH - int'(fill_slot)) begin
            fill_mask[i]          = 1'b1;
            fill_data[32*i +: 32] = PMEM_IMAGE[32*int'(fill_addr[PM_AW+1:2] + PM_AW'(i)) +: 32];
            fill_reads            = fill_reads + 32'd1;
         end
      end
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign wr_en   = accept;
         assign wr_addr = fill_addr;
         assign wr_data = fill_data;
         assign wr_mask = fill_mask;
      end else begin : g_pipe
         localparam int N = LATENCY - 1;
         logic [N-1:0]           pipe_vld_q, pipe_vld_d;
         logic [31:0]            pipe_addr_q [N];
         logic [31:0]            pipe_addr_d [N];
         logic [DW-1:0]          pipe_data_q [N];
         logic [DW-1:0]          pipe_data_d [N];
         logic [FETCH_WIDTH-1:0] pipe_mask_q [N];
         logic [FETCH_WIDTH-1:0] pipe_mask_d [N];

         always_comb begin
            pipe_vld_d     = '0;
            pipe_vld_d[0]  = accept;
            pipe_addr_d[0] = fill_addr;
            pipe_data_d[0] = fill_data;
            pipe_mask_d[0] = fill_mask;
            for (int k = 1; k < N; k++) begin
               pipe_vld_d[k]  = pipe_vld_q[k-1];
               pipe_addr_d[k] = pipe_addr_q[k-1];
               pipe_data_d[k] = pipe_data_q[k-1];
               pipe_mask_d[k] = pipe_mask_q[k-1];
            end
            if (flush_frontend) begin
               pipe_vld_d = '0;
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               pipe_vld_q <= '0;
            end else begin
               pipe_vld_q <= pipe_vld_d;
            end
            pipe_addr_q <= pipe_addr_d;
            pipe_data_q <= pipe_data_d;
            pipe_mask_q <= pipe_mask_d;
         end

         assign wr_en   = pipe_vld_q[N-1];
         assign wr_addr = pipe_addr_q[N-1];
         assign wr_data = pipe_data_q[N-1];
         assign wr_mask = pipe_mask_q[N-1];
      end
   endgenerate

   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      fifo_mask_d = fifo_mask_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_cnt_d  = fifo_cnt_q;
      if (flush_frontend) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fifo_cnt_d = '0;
      end else begin
         if (wr_en) begin
            fifo_addr_d[wr_ptr_q] = wr_addr;
            fifo_data_d[wr_ptr_q] = wr_data;
            fifo_mask_d[wr_ptr_q] = wr_mask;
            wr_ptr_d              = next_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
      end
   end

   always_comb begin
      outstanding_d = flush_frontend ? '0 : outstanding_q + CNT_W'(accept) - CNT_W'(pop);
      fetch_count_d = fetch_count_q + 32'(accept);
      pmem_reads_d  = accept ? pmem_reads_q + fill_reads : pmem_reads_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
            fifo_mask_q[i] <= '0;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         outstanding_q <= '0;
         fetch_count_q <= '0;
         pmem_reads_q  <= '0;
      end else begin
         fifo_addr_q   <= fifo_addr_d;
         fifo_data_q   <= fifo_data_d;
         fifo_mask_q   <= fifo_mask_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         outstanding_q <= outstanding_d;
         fetch_count_q <= fetch_count_d;
         pmem_reads_q  <= pmem_reads_d;
      end
   end

endmodule
